// File: rtl/saxi_full_pkg.sv
// Shared AXI burst/response codes, FSM state types and burst control payload for the AXI4 memory slave.
package saxi_full_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Latched per-burst control captured from the AW/AR channel.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } burst_ctl_t;

endpackage

// File: rtl/saxi_burst_addr.sv
// Next-beat byte address for FIXED, INCR, WRAP and reserved (treated as INCR) AXI bursts.
module saxi_burst_addr
    import saxi_full_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ADDR_LSB = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  burst_ctl_t        ctl_i,
    output logic [ADDR_W-1:0] next_addr_c_o
);

    logic [2:0]        size_eff;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;

    // Beats wider than the bus are clamped to the bus width.
    always_comb begin
        size_eff      = (ctl_i.size > 3'(ADDR_LSB)) ? 3'(ADDR_LSB) : ctl_i.size;
        step          = ADDR_W'(1) << size_eff;
        wrap_mask     = ((ADDR_W'(ctl_i.len) + ADDR_W'(1)) << size_eff) - ADDR_W'(1);
        incr_addr     = addr_i + step;
        next_addr_c_o = incr_addr;
        case (ctl_i.burst)
            BURST_FIXED: next_addr_c_o = addr_i;
            BURST_INCR:  next_addr_c_o = incr_addr;
            BURST_WRAP:  next_addr_c_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_c_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/saxi_full_v1_0_s00_axi.sv
// AXI4-full slave backed by a word memory, with independent write and read burst FSMs.
// Optional macro SAXI_BACKPRESSURE_EN throttles WREADY/RVALID with a free-running LFSR.
module saxi_full_v1_0_s00_axi
    import saxi_full_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH     = 1,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 128,
    parameter int unsigned C_S_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_S_AXI_AWUSER_WIDTH = 0,
    parameter int unsigned C_S_AXI_ARUSER_WIDTH = 0,
    parameter int unsigned C_S_AXI_WUSER_WIDTH  = 0,
    parameter int unsigned C_S_AXI_RUSER_WIDTH  = 0,
    parameter int unsigned C_S_AXI_BUSER_WIDTH  = 0,
    parameter int unsigned C_S_AXI_MEM_AW       = 20
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic [7:0]                            S_AXI_AWLEN,
    input  logic [2:0]                            S_AXI_AWSIZE,
    input  logic [1:0]                            S_AXI_AWBURST,
    input  logic                                  S_AXI_AWLOCK,
    input  logic [3:0]                            S_AXI_AWCACHE,
    input  logic [2:0]                            S_AXI_AWPROT,
    input  logic [3:0]                            S_AXI_AWQOS,
    input  logic [3:0]                            S_AXI_AWREGION,
    input  logic [((C_S_AXI_AWUSER_WIDTH > 0) ? C_S_AXI_AWUSER_WIDTH : 1)-1:0] S_AXI_AWUSER,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                                  S_AXI_WLAST,
    input  logic [((C_S_AXI_WUSER_WIDTH > 0) ? C_S_AXI_WUSER_WIDTH : 1)-1:0] S_AXI_WUSER,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_BID,
    output logic [1:0]                            S_AXI_BRESP,
    output logic [((C_S_AXI_BUSER_WIDTH > 0) ? C_S_AXI_BUSER_WIDTH : 1)-1:0] S_AXI_BUSER,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic [7:0]                            S_AXI_ARLEN,
    input  logic [2:0]                            S_AXI_ARSIZE,
    input  logic [1:0]                            S_AXI_ARBURST,
    input  logic                                  S_AXI_ARLOCK,
    input  logic [3:0]                            S_AXI_ARCACHE,
    input  logic [2:0]                            S_AXI_ARPROT,
    input  logic [3:0]                            S_AXI_ARQOS,
    input  logic [3:0]                            S_AXI_ARREGION,
    input  logic [((C_S_AXI_ARUSER_WIDTH > 0) ? C_S_AXI_ARUSER_WIDTH : 1)-1:0] S_AXI_ARUSER,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RLAST,
    output logic [((C_S_AXI_RUSER_WIDTH > 0) ? C_S_AXI_RUSER_WIDTH : 1)-1:0] S_AXI_RUSER,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY
);

    localparam int unsigned ID_W      = C_S_AXI_ID_WIDTH;
    localparam int unsigned ADDR_W    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DATA_W    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned ADDR_LSB  = $clog2(STRB_W);
    localparam int unsigned MEM_AW    = C_S_AXI_MEM_AW;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    wstate_e           wstate_q, wstate_d;
    logic [ID_W-1:0]   awid_q, awid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, waddr_next;
    burst_ctl_t        wctl_q, wctl_d;
    logic [7:0]        wbeat_q, wbeat_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;

    rstate_e           rstate_q, rstate_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, raddr_next;
    burst_ctl_t        rctl_q, rctl_d;
    logic [7:0]        rbeat_q, rbeat_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              bp_gate_c;
    logic [MEM_AW-1:0] widx_c, ridx_c;

    logic [DATA_W-1:0] mem_q [0:MEM_DEPTH-1];

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID  && wready_q;
    assign b_hs  = S_AXI_BREADY  && bvalid_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;
    assign r_hs  = S_AXI_RREADY  && rvalid_q;

`ifdef SAXI_BACKPRESSURE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci taps 16,14,13,11; the gate uses the next value so the registered handshakes track lfsr_q[0].
    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign bp_gate_c = lfsr_d[0];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) lfsr_q <= LFSR_SEED;
        else                lfsr_q <= lfsr_d;
    end
`else
    assign bp_gate_c = 1'b1;
`endif

    saxi_burst_addr #(.ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB)) u_waddr (
        .addr_i        (awaddr_q),
        .ctl_i         (wctl_q),
        .next_addr_c_o (waddr_next)
    );

    saxi_burst_addr #(.ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB)) u_raddr (
        .addr_i        (araddr_q),
        .ctl_i         (rctl_q),
        .next_addr_c_o (raddr_next)
    );

    // Write channel: the burst length comes from AWLEN alone; WLAST is not consulted.
    always_comb begin
        wstate_d = wstate_q;
        awid_d   = awid_q;
        awaddr_d = awaddr_q;
        wctl_d   = wctl_q;
        wbeat_d  = wbeat_q;
        case (wstate_q)
            W_IDLE: if (aw_hs) begin
                awid_d   = S_AXI_AWID;
                awaddr_d = S_AXI_AWADDR;
                wctl_d   = '{len: S_AXI_AWLEN, size: S_AXI_AWSIZE, burst: S_AXI_AWBURST};
                wbeat_d  = 8'd0;
                wstate_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                awaddr_d = waddr_next;
                wbeat_d  = wbeat_q + 8'd1;
                if (wbeat_q == wctl_q.len) wstate_d = W_RESP;
            end
            W_RESP: if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA) && bp_gate_c;
        bvalid_d  = (wstate_d == W_RESP);
    end

    // Read channel: RDATA is a combinational memory read at the current beat address.
    always_comb begin
        rstate_d = rstate_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        rctl_d   = rctl_q;
        rbeat_d  = rbeat_q;
        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                arid_d   = S_AXI_ARID;
                araddr_d = S_AXI_ARADDR;
                rctl_d   = '{len: S_AXI_ARLEN, size: S_AXI_ARSIZE, burst: S_AXI_ARBURST};
                rbeat_d  = 8'd0;
                rstate_d = R_DATA;
            end
            R_DATA: if (r_hs) begin
                if (rbeat_q == rctl_q.len) begin
                    rstate_d = R_IDLE;
                end else begin
                    araddr_d = raddr_next;
                    rbeat_d  = rbeat_q + 8'd1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA) && bp_gate_c;
        rlast_d   = (rstate_d == R_DATA) && (rbeat_d == rctl_d.len);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q  <= W_IDLE;
            awid_q    <= '0;
            awaddr_q  <= '0;
            wctl_q    <= '0;
            wbeat_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rstate_q  <= R_IDLE;
            arid_q    <= '0;
            araddr_q  <= '0;
            rctl_q    <= '0;
            rbeat_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            wctl_q    <= wctl_d;
            wbeat_q   <= wbeat_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            rstate_q  <= rstate_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            rctl_q    <= rctl_d;
            rbeat_q   <= rbeat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    assign widx_c = awaddr_q[ADDR_LSB +: MEM_AW];
    assign ridx_c = araddr_q[ADDR_LSB +: MEM_AW];

    // Memory is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (S_AXI_WSTRB[b]) mem_q[widx_c][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = awid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_BUSER   = '0;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = arid_q;
    assign S_AXI_RDATA   = mem_q[ridx_c];
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RUSER   = '0;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                             S_AXI_AWUSER, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                             S_AXI_ARREGION, S_AXI_ARUSER, S_AXI_WLAST, S_AXI_WUSER};

endmodule

// File: tb/tb_saxi_full_v1_0_s00_axi.sv
// Self-checking bench for saxi_full_v1_0_s00_axi: directed and randomized bursts against a byte-merge memory model.
module tb_saxi_full_v1_0_s00_axi;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned STRB_W = 16;
    localparam int unsigned MEM_AW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [0:0]        awid, bid, arid, rid;
    logic [31:0]       awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize, awprot, arprot;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awlock, arlock;
    logic [3:0]        awcache, arcache, awqos, arqos, awregion, arregion;
    logic [0:0]        awuser, aruser, wuser, buser, ruser;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [STRB_W-1:0] wstrb;

    saxi_full_v1_0_s00_axi #(
        .C_S_AXI_ID_WIDTH(1), .C_S_AXI_DATA_WIDTH(128), .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_AWUSER_WIDTH(0), .C_S_AXI_ARUSER_WIDTH(0), .C_S_AXI_WUSER_WIDTH(0),
        .C_S_AXI_RUSER_WIDTH(0), .C_S_AXI_BUSER_WIDTH(0), .C_S_AXI_MEM_AW(20)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(awlock), .S_AXI_AWCACHE(awcache), .S_AXI_AWPROT(awprot),
        .S_AXI_AWQOS(awqos), .S_AXI_AWREGION(awregion), .S_AXI_AWUSER(awuser), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(wuser),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(arlock), .S_AXI_ARCACHE(arcache), .S_AXI_ARPROT(arprot),
        .S_AXI_ARQOS(arqos), .S_AXI_ARREGION(arregion), .S_AXI_ARUSER(aruser), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [DATA_W-1:0] model [int unsigned];
    logic [DATA_W-1:0] wd [256];
    logic [STRB_W-1:0] ws [256];

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte address of beat n, straight from the AXI burst rules.
    function automatic int unsigned beat_addr(input int unsigned a, input int unsigned len,
                                              input int unsigned size, input int unsigned burst,
                                              input int unsigned n);
        int unsigned bytes;
        int unsigned win;
        int unsigned lo;
        bytes = 1 << ((size > 4) ? 4 : size);
        win   = bytes * (len + 1);
        case (burst)
            0: return a;
            2: begin
                lo = (a / win) * win;
                return lo + ((a - lo + n * bytes) % win);
            end
            default: return a + n * bytes;
        endcase
    endfunction

    function automatic int unsigned word_of(input int unsigned a);
        return (a >> 4) & ((1 << MEM_AW) - 1);
    endfunction

    function automatic logic [DATA_W-1:0] mrd(input int unsigned w);
        return model.exists(w) ? model[w] : '0;
    endfunction

    task automatic model_wr(input int unsigned w, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] v;
        v = mrd(w);
        for (int b = 0; b < int'(STRB_W); b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        model[w] = v;
    endtask

    task automatic axi_write(input int unsigned id, input int unsigned addr, input int unsigned len,
                             input int unsigned size, input int unsigned burst, input int abort_at);
        int unsigned n;
        int budget;
        awid = 1'(id); awaddr = 32'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awlock = 1'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
        awqos = 4'($urandom); awregion = 4'($urandom); awuser = 1'($urandom);
        awvalid = 1'b1;
        budget = 0;
        while (!awready && budget < 100) begin tick(); budget++; end
        if (!awready) begin chk("aw_timeout", 128'(awready), 128'(1)); awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        n = 0; budget = 0;
        while (n <= len && budget < 3000) begin
            if (abort_at >= 0 && int'(n) == abort_at) begin wvalid = 1'b0; return; end
            wvalid = ($urandom_range(0, 3) != 0);
            wdata = wd[n]; wstrb = ws[n]; wlast = (n == len); wuser = 1'($urandom);
            if (wvalid && wready) begin
                model_wr(word_of(beat_addr(addr, len, size, burst, n)), wd[n], ws[n]);
                n++;
            end
            tick(); budget++;
        end
        wvalid = 1'b0;
        if (n <= len) begin chk("w_timeout", 128'(n), 128'(len + 1)); return; end
        budget = 0;
        while (budget < 200) begin
            bready = ($urandom_range(0, 1) == 1);
            if (bvalid && bready) break;
            tick(); budget++;
        end
        if (budget >= 200) begin chk("b_timeout", 128'(bvalid), 128'(1)); bready = 1'b0; return; end
        chk("bid", 128'(bid), 128'(id));
        chk("bresp", 128'(bresp), 128'(0));
        chk("buser", 128'(buser), 128'(0));
        tick();
        bready = 1'b0;
        chk("bvalid_drop", 128'(bvalid), 128'(0));
    endtask

    task automatic axi_read(input int unsigned id, input int unsigned addr, input int unsigned len,
                            input int unsigned size, input int unsigned burst, input int stall);
        int unsigned n;
        int budget;
        int hold;
        logic [DATA_W-1:0] exp;
        arid = 1'(id); araddr = 32'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arlock = 1'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
        arqos = 4'($urandom); arregion = 4'($urandom); aruser = 1'($urandom);
        arvalid = 1'b1;
        budget = 0;
        while (!arready && budget < 100) begin tick(); budget++; end
        if (!arready) begin chk("ar_timeout", 128'(arready), 128'(1)); arvalid = 1'b0; return; end
        tick();
        arvalid = 1'b0;
        n = 0; budget = 0; hold = stall;
        while (n <= len && budget < 3000) begin
            exp = mrd(word_of(beat_addr(addr, len, size, burst, n)));
            if (hold > 0) begin
                rready = 1'b0;
                hold--;
                if (rvalid) begin
                    chk("stall_rdata", rdata, exp);
                    chk("stall_rlast", 128'(rlast), 128'(len == 0));
                end
            end else begin
                rready = ($urandom_range(0, 3) != 0);
            end
            if (rvalid && rready) begin
                chk($sformatf("rdata[%0d]@%h", n, addr), rdata, exp);
                chk("rlast", 128'(rlast), 128'(n == len));
                chk("rid", 128'(rid), 128'(id));
                chk("rresp", 128'(rresp), 128'(0));
                n++;
            end
            tick(); budget++;
        end
        rready = 1'b0;
        if (n <= len) begin chk("r_timeout", 128'(n), 128'(len + 1)); return; end
        chk("rvalid_drop", 128'(rvalid), 128'(0));
        chk("ruser", 128'(ruser), 128'(0));
    endtask

    task automatic fill_random(input int unsigned beats, input bit full_strb);
        for (int i = 0; i < int'(beats); i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = full_strb ? '1 : STRB_W'($urandom);
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_awready"}, 128'(awready), 128'(0));
        chk({pfx, "_wready"},  128'(wready),  128'(0));
        chk({pfx, "_bvalid"},  128'(bvalid),  128'(0));
        chk({pfx, "_arready"}, 128'(arready), 128'(0));
        chk({pfx, "_rvalid"},  128'(rvalid),  128'(0));
        chk({pfx, "_rlast"},   128'(rlast),   128'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned burst, size, len, addr, bytes;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0; awcache = '0;
        awprot = '0; awqos = '0; awregion = '0; awuser = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0; arcache = '0;
        arprot = '0; arqos = '0; arregion = '0; aruser = '0; arvalid = 1'b0; rready = 1'b0;

        tick(); tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(); tick();
        chk("post_reset_awready", 128'(awready), 128'(1));
        chk("post_reset_arready", 128'(arready), 128'(1));

        // INCR 4-beat write of 1..4, read back with a stalled first beat.
        for (int i = 0; i < 4; i++) begin wd[i] = 128'(i + 1); ws[i] = '1; end
        axi_write(0, 32'h1000_0000, 3, 4, 1, -1);
        axi_read(0, 32'h1000_0000, 3, 4, 1, 5);

        // Single-byte strobe merge onto a patterned word.
        wd[0] = {4{32'h5555_5555}}; ws[0] = '1;
        axi_write(1, 32'h0000_0500, 0, 4, 1, -1);
        wd[0] = 128'hFF; ws[0] = 16'h0001;
        axi_write(1, 32'h0000_0500, 0, 4, 1, -1);
        axi_read(1, 32'h0000_0500, 0, 4, 1, 0);

        // WRAP write from 0x30 lands on 0x30,0x00,0x10,0x20; read both linearly and wrapped.
        fill_random(4, 1'b1);
        axi_write(0, 32'h0000_0030, 3, 4, 2, -1);
        axi_read(0, 32'h0000_0000, 3, 4, 1, 0);
        axi_read(1, 32'h0000_0030, 3, 4, 2, 0);

        // Concurrent 64-beat write and read to disjoint regions.
        fill_random(64, 1'b1);
        axi_write(1, 32'h0000_8000, 63, 4, 1, -1);
        fill_random(64, 1'b0);
        fork
            axi_write(1, 32'h0004_0000, 63, 4, 1, -1);
            axi_read(1, 32'h0000_8000, 63, 4, 1, 0);
        join
        axi_read(1, 32'h0004_0000, 63, 4, 1, 0);

        // Reset during the third write beat: handshakes drop, first two beats persist.
        fill_random(4, 1'b1);
        axi_write(0, 32'h0000_2000, 3, 4, 1, 2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midburst_reset");
        tick();
        rst_n = 1'b1;
        tick(); tick();
        axi_read(0, 32'h0000_2000, 3, 4, 1, 0);
        fill_random(2, 1'b1);
        axi_write(1, 32'h0000_2000, 1, 4, 1, -1);
        axi_read(1, 32'h0000_2000, 3, 4, 1, 0);

        // Randomized bursts with aliased upper address bits, partial strobes and every burst type.
        for (int t = 0; t < 40; t++) begin
            burst = $urandom_range(0, 3);
            size  = $urandom_range(0, 7);
            bytes = 1 << ((size > 4) ? 4 : size);
            if (burst == 2) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = $urandom_range(0, 32'h3FFF) | ($urandom_range(0, 255) << 24);
            if (burst == 2) addr = addr & ~(bytes - 1);
            fill_random(len + 1, ($urandom_range(0, 1) == 1));
            axi_write($urandom_range(0, 1), addr, len, size, burst, -1);
            axi_read($urandom_range(0, 1), addr, len, size, burst, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
